// File: rtl/mips_pkg.sv
// Shared pipeline definitions used by the execute-stage divider.
package mips_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake and result bus.
interface div_unit_if;

    logic                        div_start;
    logic                        div_signed;
    logic [mips_pkg::DIV_W-1:0]  src1;
    logic [mips_pkg::DIV_W-1:0]  src2;
    logic                        div_cancel;
    logic                        div_block;
    logic                        div_done;
    logic [mips_pkg::DIV_W-1:0]  quotient;
    logic [mips_pkg::DIV_W-1:0]  remainder;

    modport master (
        output div_start, div_signed, src1, src2, div_cancel,
        input  div_block, div_done, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, src1, src2, div_cancel,
        output div_block, div_done, quotient, remainder
    );

endinterface

// File: rtl/div_abs.sv
// Per-lane two's-complement conditional negate: magnitude extraction when
// neg is the sign bit, sign restoration when neg is the wanted sign.
module div_abs #(
    parameter int W = 32,
    parameter int N = 2
) (
    input  logic [N-1:0][W-1:0] din,
    input  logic [N-1:0]        neg,
    output logic [N-1:0][W-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign dout[gi] = neg[gi] ? (~din[gi] + W'(1)) : din[gi];
        end
    endgenerate

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU (HI/LO).
// Optional macro DIV_ZERO_FAST_EN: zero divisor skips the iterations.
module div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic      clk,
    input  logic      resetn,
    div_unit_if.slave bus
);

    localparam int RW = 2 * DATA_W;

    div_state_t               state_q, state_d;
    logic [DIV_CNT_W-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic [DATA_W-1:0]        dvs_q, dvs_d;
    logic [DATA_W-1:0]        quo_q, quo_d;
    logic [DATA_W-1:0]        rmd_q, rmd_d;
    logic                     q_neg_q, q_neg_d;
    logic                     r_neg_q, r_neg_d;

    logic                     src1_neg, src2_neg;
    logic [DATA_W:0]          trial;
    logic [1:0][DATA_W-1:0]   op_abs;
    logic [1:0][DATA_W-1:0]   res_fix;

    assign src1_neg = bus.div_signed & bus.src1[DATA_W-1];
    assign src2_neg = bus.div_signed & bus.src2[DATA_W-1];

    div_abs #(.W(DATA_W), .N(2)) u_op_abs (
        .din  ({bus.src2, bus.src1}),
        .neg  ({src2_neg, src1_neg}),
        .dout (op_abs)
    );

    // rem_q holds {partial remainder, dividend bits / quotient bits}
    div_abs #(.W(DATA_W), .N(2)) u_res_fix (
        .din  ({rem_q[RW-1:DATA_W], rem_q[DATA_W-1:0]}),
        .neg  ({r_neg_q, q_neg_q}),
        .dout (res_fix)
    );

    // Upper half after the shift needs DATA_W+1 bits when divisor > 2^(W-1)
    assign trial = rem_q[RW-1:DATA_W-1] - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        if (bus.div_cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.div_start) begin
                        rem_d   = {{DATA_W{1'b0}}, op_abs[0]};
                        dvs_d   = op_abs[1];
                        q_neg_d = src1_neg ^ src2_neg;
                        r_neg_d = src1_neg;
                        cnt_d   = '0;
                        state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.src2 == '0) begin
                            rem_d   = {op_abs[0], {DATA_W{1'b1}}};
                            state_d = DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (trial[DATA_W]) begin
                        rem_d = {rem_q[RW-2:0], 1'b0};
                    end else begin
                        rem_d = {trial[DATA_W-1:0], rem_q[DATA_W-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + DIV_CNT_W'(1);
                    if (cnt_q == DIV_CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    quo_d   = res_fix[0];
                    rmd_d   = res_fix[1];
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    // Results are presented during the done pulse and only committed when
    // DONE completes, so a flush in DONE leaves the held results untouched.
    assign bus.div_block = resetn && !bus.div_cancel &&
                           (((state_q == IDLE) && bus.div_start) || (state_q == BUSY));
    assign bus.div_done  = (state_q == DONE) && !bus.div_cancel;
    assign bus.quotient  = (state_q == DONE) ? res_fix[0] : quo_q;
    assign bus.remainder = (state_q == DONE) ? res_fix[1] : rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected HI/LO per divide,
// plus stall timing, flush and mid-operation reset scenarios.
module tb_div_unit;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    div_unit_if bus ();

    div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends DONE.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
        int   done_cyc;
        bit   seen;
        exp_t e;
        done_cyc = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) done_cyc = 1;
`endif
        sb_q.push_back('{q: eq, r: er});
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.src1       = a;
        bus.src2       = b;
        seen = 1'b0;
        for (int c = 0; c <= done_cyc + 2 && !seen; c++) begin
            @(negedge clk);
            chk($sformatf("block_c%0d", c), 32'(bus.div_block), 32'(c < done_cyc));
            if (bus.div_done) begin
                seen = 1'b1;
                chk("done_cycle", c, done_cyc);
                e = sb_q.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
            end
            @(posedge clk);
            #1;
            bus.src1 = $urandom;
            bus.src2 = $urandom;
            if (seen) bus.div_start = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        bus.div_start = 1'b0;
        $display("div sgn=%0d %h / %h -> q=%h r=%h", sgn, a, b, bus.quotient, bus.remainder);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn         = 1'b0;
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.src1       = 32'd100;
        bus.src2       = 32'd7;
        bus.div_cancel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_block", 32'(bus.div_block), 32'd0);
        chk("rst_done", 32'(bus.div_done), 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        bus.div_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_div(1'b0, 32'd100,        32'd7,        32'd14,       32'd2);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_div(1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0);
        do_div(1'b0, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1,        32'h7FFF_FFFE);
        do_div(1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5);

        // Flush in cycle 10 of a divide
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.src1       = 32'd1000;
        bus.src2       = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("cancel_pre_block", 32'(bus.div_block), 32'd1);
            chk("cancel_pre_done", 32'(bus.div_done), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.div_cancel = 1'b1;
        @(negedge clk);
        chk("cancel_block", 32'(bus.div_block), 32'd0);
        chk("cancel_done", 32'(bus.div_done), 32'd0);
        @(posedge clk);
        #1;
        bus.div_cancel = 1'b0;
        bus.div_start  = 1'b0;
        chk("cancel_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        chk("cancel_idle_block", 32'(bus.div_block), 32'd0);
        chk("cancel_idle_done", 32'(bus.div_done), 32'd0);
        chk("cancel_keep_q", bus.quotient, 32'hFFFF_FFFF);
        chk("cancel_keep_r", bus.remainder, 32'd5);
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        $display("cancel scenario: restart q=%h r=%h", bus.quotient, bus.remainder);

        // Asynchronous reset in cycle 20 of a divide
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.src1       = 32'd1000;
        bus.src2       = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_block", 32'(bus.div_block), 32'd0);
        chk("arst_done", 32'(bus.div_done), 32'd0);
        chk("arst_quotient", bus.quotient, 32'd0);
        chk("arst_remainder", bus.remainder, 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'(IDLE));
        bus.div_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
